// File: rtl/rf_riscv_scb_if.sv
// Register-file / scoreboard port bundle: read, write and issue signals plus hazard outputs.
// master = decode/writeback side driving addresses and data, slave = the register file.
interface rf_riscv_scb_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic              WE;
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [ADDR_W-1:0] A3;
    logic [XLEN-1:0]   WD3;
    logic [XLEN-1:0]   RD1;
    logic [XLEN-1:0]   RD2;
    logic              ISSUE;
    logic [ADDR_W-1:0] AI;
    logic              BUSY1;
    logic              BUSY2;
    logic              BUSYI;
    logic [ADDR_W:0]   BUSY_CNT;

    modport master (
        output WE, A1, A2, A3, WD3, ISSUE, AI,
        input  RD1, RD2, BUSY1, BUSY2, BUSYI, BUSY_CNT
    );

    modport slave (
        input  WE, A1, A2, A3, WD3, ISSUE, AI,
        output RD1, RD2, BUSY1, BUSY2, BUSYI, BUSY_CNT
    );
endinterface

// File: rtl/rf_riscv_scb.sv
// Register file (2 async read, 1 sync write, x0 = 0) with per-register busy scoreboard.
// Reads are zero latency (optional same-cycle write bypass); writes and busy updates take one edge; no backpressure.
module rf_riscv_scb #(
    parameter int              XLEN      = 32,
    parameter int              ADDR_W    = 5,
    parameter int              BYPASS    = 1,
    parameter logic [XLEN-1:0] RESET_VAL = '0
) (
    input logic           clk,
    input logic           rst_n,
    rf_riscv_scb_if.slave bus
);
    localparam int   NREGS = 2**ADDR_W;
    localparam int   CW    = ADDR_W + 1;
    localparam logic BYP   = (BYPASS != 0);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             wr;
    logic             iss;
    logic             fwd1;
    logic             fwd2;
    logic             wr_ai;

    assign wr  = bus.WE && (bus.A3 != '0);
    assign iss = bus.ISSUE && (bus.AI != '0);

    // Set is applied after clear so a re-issue in the writeback cycle keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (wr)  busy_nxt[bus.A3] = 1'b0;
        if (iss) busy_nxt[bus.AI] = 1'b1;
        busy_nxt[0] = 1'b0;
        cnt_nxt = '0;
        for (int i = 1; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == 0) ? '0 : RESET_VAL;
            end
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (wr) regs[bus.A3] <= bus.WD3;
            busy <= busy_nxt;
            cnt  <= cnt_nxt;
        end
    end

    assign fwd1  = BYP && wr && (bus.A3 == bus.A1);
    assign fwd2  = BYP && wr && (bus.A3 == bus.A2);
    assign wr_ai = wr && (bus.A3 == bus.AI);

    assign bus.RD1 = (bus.A1 == '0) ? '0 : (fwd1 ? bus.WD3 : regs[bus.A1]);
    assign bus.RD2 = (bus.A2 == '0) ? '0 : (fwd2 ? bus.WD3 : regs[bus.A2]);

    // WAW check looks at next-state availability, so the writeback clear counts even without bypass.
    assign bus.BUSY1    = busy[bus.A1] & ~fwd1;
    assign bus.BUSY2    = busy[bus.A2] & ~fwd2;
    assign bus.BUSYI    = busy[bus.AI] & ~wr_ai;
    assign bus.BUSY_CNT = cnt;
endmodule

// File: tb/tb_rf_riscv_scb.sv
// Drives a BYPASS=0 and a BYPASS=1 instance with identical stimulus; a monitor checks both
// against expectations queued from a register-array reference model.
module tb_rf_riscv_scb;
    localparam logic [31:0] RV0 = 32'hA5A5_0F0F;
    localparam logic [31:0] RV1 = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        we, issue;
    logic [4:0]  a1, a2, a3, ai;
    logic [31:0] wd3;

    rf_riscv_scb_if #(.XLEN(32), .ADDR_W(5)) bus0 ();
    rf_riscv_scb_if #(.XLEN(32), .ADDR_W(5)) bus1 ();

    assign bus0.WE = we;   assign bus1.WE = we;
    assign bus0.A1 = a1;   assign bus1.A1 = a1;
    assign bus0.A2 = a2;   assign bus1.A2 = a2;
    assign bus0.A3 = a3;   assign bus1.A3 = a3;
    assign bus0.WD3 = wd3; assign bus1.WD3 = wd3;
    assign bus0.ISSUE = issue; assign bus1.ISSUE = issue;
    assign bus0.AI = ai;   assign bus1.AI = ai;

    rf_riscv_scb #(.XLEN(32), .ADDR_W(5), .BYPASS(0), .RESET_VAL(RV0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    rf_riscv_scb #(.XLEN(32), .ADDR_W(5), .BYPASS(1), .RESET_VAL(RV1)) u_byp (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = no-bypass instance, 1 = bypass instance.
    logic [31:0] mregs [2][32];
    bit          mbusy [32];

    typedef struct packed {
        logic [1:0][31:0] rd1;
        logic [1:0][31:0] rd2;
        logic [1:0]       bs1;
        logic [1:0]       bs2;
        logic             bsi;
        logic [5:0]       cnt;
    } exp_t;

    exp_t exp_q [$];

    function automatic logic [31:0] rv(input int k);
        return (k == 0) ? RV0 : RV1;
    endfunction

    function automatic bit writing(input logic [4:0] a);
        return we && a3 != 0 && a3 == a;
    endfunction

    function automatic logic [31:0] m_read(input int k, input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (k == 1 && writing(a)) return wd3;
        return mregs[k][a];
    endfunction

    function automatic bit m_busy(input int k, input logic [4:0] a);
        if (a == 0) return 1'b0;
        return mbusy[a] && !(k == 1 && writing(a));
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            e.rd1[k] = m_read(k, a1);
            e.rd2[k] = m_read(k, a2);
            e.bs1[k] = m_busy(k, a1);
            e.bs2[k] = m_busy(k, a2);
        end
        e.bsi = (ai != 0) && mbusy[ai] && !writing(ai);
        e.cnt = 6'(m_count());
        return e;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) mregs[k][i] = (i == 0) ? 32'h0 : rv(k);
        for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    endtask

    task automatic m_edge();
        if (we && a3 != 0) begin
            mregs[0][a3] = wd3;
            mregs[1][a3] = wd3;
            mbusy[a3] = 1'b0;
        end
        if (issue && ai != 0) mbusy[ai] = 1'b1;
    endtask

    // Inputs are set at posedge+1; the expectation is queued, then the model steps at the edge.
    task automatic cycle();
        exp_q.push_back(predict());
        @(posedge clk);
        if (rst_n) m_edge();
        #1;
    endtask

    task automatic idle();
        we = 0; issue = 0; a1 = 0; a2 = 0; a3 = 0; ai = 0; wd3 = 0;
    endtask

    task automatic set_wr(input logic [4:0] a, input logic [31:0] d);
        we = 1; a3 = a; wd3 = d;
    endtask

    task automatic set_iss(input logic [4:0] a);
        issue = 1; ai = a;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rd1_nobyp",  64'(bus0.RD1),   64'(e.rd1[0]));
            chk("rd1_byp",    64'(bus1.RD1),   64'(e.rd1[1]));
            chk("rd2_nobyp",  64'(bus0.RD2),   64'(e.rd2[0]));
            chk("rd2_byp",    64'(bus1.RD2),   64'(e.rd2[1]));
            chk("busy1_nobyp", 64'(bus0.BUSY1), 64'(e.bs1[0]));
            chk("busy1_byp",   64'(bus1.BUSY1), 64'(e.bs1[1]));
            chk("busy2_nobyp", 64'(bus0.BUSY2), 64'(e.bs2[0]));
            chk("busy2_byp",   64'(bus1.BUSY2), 64'(e.bs2[1]));
            chk("busyi_nobyp", 64'(bus0.BUSYI), 64'(e.bsi));
            chk("busyi_byp",   64'(bus1.BUSYI), 64'(e.bsi));
            chk("cnt_nobyp",  64'(bus0.BUSY_CNT), 64'(e.cnt));
            chk("cnt_byp",    64'(bus1.BUSY_CNT), 64'(e.cnt));
        end
    end

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        m_reset();
        @(posedge clk); #1;
        cycle();
        a1 = 5; a2 = 31; cycle();
        rst_n = 1'b1;

        // Async reset mid-cycle clears data and busy state before any edge.
        idle(); set_wr(5, 32'hDEADBEEF); set_iss(7); cycle();
        idle(); a1 = 5; a2 = 7; cycle();
        rst_n = 1'b0;
        m_reset();
        cycle();
        rst_n = 1'b1;
        chk("post_reset_cnt", 64'(bus1.BUSY_CNT), 64'd0);

        // x0 write and issue are ignored.
        idle(); set_wr(0, 32'h12345678); set_iss(0); cycle();
        idle(); cycle();

        // Same-cycle bypass vs stored value.
        idle(); set_wr(3, 32'h11); cycle();
        idle(); set_wr(3, 32'h22); a1 = 3; cycle();
        idle(); a1 = 3; cycle();

        // Busy lifecycle on x9.
        idle(); set_iss(9); cycle();
        idle(); a1 = 9; cycle();
        idle(); set_wr(9, 32'hAB); a1 = 9; cycle();
        idle(); a1 = 9; cycle();

        // Writeback and re-issue of x4 in one cycle.
        idle(); set_iss(4); cycle();
        idle(); set_wr(4, 32'h55); set_iss(4); a1 = 4; cycle();
        idle(); a1 = 4; ai = 4; cycle();

        // Fill the scoreboard, re-issue the last, then drain it.
        for (int i = 1; i < 32; i++) begin
            idle(); set_iss(5'(i)); a1 = 5'(i); a2 = 5'(i - 1); cycle();
        end
        chk("full_cnt_byp",   64'(bus1.BUSY_CNT), 64'd31);
        chk("full_cnt_nobyp", 64'(bus0.BUSY_CNT), 64'd31);
        idle(); set_iss(31); cycle();
        chk("reissue_cnt", 64'(bus1.BUSY_CNT), 64'd31);
        for (int i = 1; i < 32; i++) begin
            idle(); set_wr(5'(i), $urandom); a1 = 5'(i); a2 = 5'(32 - i); cycle();
        end
        chk("drained_cnt", 64'(bus0.BUSY_CNT), 64'd0);

        // Randomized traffic with occasional async reset pulses.
        for (int n = 0; n < 3000; n++) begin
            we = 1'($urandom_range(0, 1));
            issue = 1'($urandom_range(0, 1));
            a1 = raddr(); a2 = raddr(); a3 = raddr(); ai = raddr();
            if ($urandom_range(0, 7) == 0) a1 = a3;
            if ($urandom_range(0, 7) == 0) ai = a3;
            wd3 = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                we = 0;
                rst_n = 1'b0;
                m_reset();
                cycle();
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end

        idle(); cycle();
        @(negedge clk); #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rf_riscv_scb.md
Name: rf_riscv_scb

Overview:
- Parametrised successor to the core register file: 2 asynchronous read ports, 1 synchronous write port, x0 hard-wired to zero.
- Adds asynchronous active-low reset of all registers.
- Adds optional write-to-read bypass.
- Adds a per-register busy scoreboard. The decode stage uses it to detect RAW/WAW hazards against in-flight destinations in the pipelined core.

Parameters:
XLEN, 32, data width of each register
ADDR_W, 5, address width; register count NREGS = 2**ADDR_W
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns stored value only
RESET_VAL, 0, value loaded into every register (except x0) on reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
WE  in  1  write enable for port 3
A1  in  ADDR_W  read address port 1
A2  in  ADDR_W  read address port 2
A3  in  ADDR_W  write address
WD3  in  XLEN  write data
RD1  out  XLEN  read data port 1
RD2  out  XLEN  read data port 2
ISSUE  in  1  instruction with destination AI issued this cycle; marks AI busy
AI  in  ADDR_W  destination register of issuing instruction
BUSY1  out  1  register A1 has a pending write (not yet available)
BUSY2  out  1  register A2 has a pending write
BUSYI  out  1  register AI already busy (WAW hazard)
BUSY_CNT  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - rst_n low asynchronously sets every regs[i] (i != 0) to RESET_VAL and clears all busy bits.
  - Outputs settle combinationally during reset: RD1/RD2 = RESET_VAL (0 for x0), BUSY1/BUSY2/BUSYI = 0, BUSY_CNT = 0.
  - Reset deassertion is synchronised externally; after deassertion, the first edge behaves normally.
- Write:
  - On posedge clk, if WE and A3 != 0, then regs[A3] <= WD3.
  - WE with A3 == 0 is ignored: no storage change, no busy change.
- Read:
  - Combinational, zero latency.
  - RDn = 0 if An == 0.
  - Else, if BYPASS == 1 and WE and A3 == An, RDn = WD3.
  - Else RDn = regs[An].
- Scoreboard:
  - One busy bit per register; busy[0] is constant 0.
  - On posedge clk:
    - If WE and A3 != 0: clear busy[A3].
    - Then, if ISSUE and AI != 0: set busy[AI].
    - Set has priority over clear when A3 == AI in the same cycle: the new producer supersedes, so the bit ends at 1 and the register data still takes WD3.
  - WE to a non-busy register is legal: data is written and the bit stays 0.
  - ISSUE to an already-busy register is legal: the bit stays 1 and BUSYI = 1 that cycle. Decode is expected to stall, but the block does not block the issue.
- Busy outputs (combinational):
  - BUSYn = busy[An] & ~(BYPASS & WE & (A3 == An)), for n in {1, 2}.
  - BUSYI = busy[AI] & ~(WE & (A3 == AI)). The clear applies regardless of BYPASS because it describes next-state availability.
  - All busy outputs are 0 when the address is 0.
- BUSY_CNT:
  - A registered population count of busy bits, updated on the same edge as the busy bits; it reflects post-edge state.
  - Range 0..NREGS-1, so it never overflows.
- No internal latency beyond the one write edge: data written at edge k is visible on RDn directly after edge k with BYPASS == 0, and during cycle k with BYPASS == 1.

Test Plan:
- Reset: write regs[5] = 0xDEADBEEF and issue x7. Pulse rst_n low mid-cycle (asynchronously), A1 = 5, A2 = 7 -> RD1 = 0 and BUSY2 = 0 immediately, without waiting for a clk edge; BUSY_CNT = 0.
- x0 protection: WE = 1, A3 = 0, WD3 = 0x12345678, ISSUE = 1, AI = 0 -> RD1(A1 = 0) = 0, BUSYI = 0, BUSY_CNT unchanged.
- Bypass, both settings: regs[3] = 0x11. Apply WE = 1, A3 = 3, WD3 = 0x22, A1 = 3 in the same cycle -> RD1 = 0x22 with BYPASS = 1 and 0x11 with BYPASS = 0; after the edge, RD1 = 0x22 in both.
- Scoreboard lifecycle: ISSUE AI = 9 -> next cycle BUSY1(A1 = 9) = 1 and BUSY_CNT = 1. Then WE A3 = 9, WD3 = 0xAB -> BUSY1 drops combinationally that cycle if BYPASS = 1, and is 0 after the edge; BUSY_CNT = 0.
- Simultaneous set/clear: x4 busy; same cycle WE A3 = 4, WD3 = 0x55, ISSUE AI = 4 -> after the edge regs[4] = 0x55, busy[4] = 1, BUSY_CNT unchanged.
- Full scoreboard, ADDR_W = 5: issue x1..x31 on consecutive cycles -> BUSY_CNT = 31. Re-issue x31 -> BUSYI = 1 and the count stays 31. Then write back all 31 -> BUSY_CNT = 0.
